timer_array: RTL and testbench
==============================

Name: timer_array

Overview:
- Memory-mapped array of NCH independent up-counters/timers on the CPU native bus (valid/ready/wstrb/addr/wdata/rdata).
- Each channel has a per-channel prescaler, a programmable wrap value (MAX), periodic or one-shot mode, a sticky overflow flag and an interrupt enable.
- Sits beside the other bus peripherals. Drives per-channel overflow pulses and one combined level interrupt to the CPU.

Parameters:
- NCH, 4, number of channels (1..16).
- WIDTH, 32, counter and MAX width in bits (1..32). Narrower values are zero-extended on read and truncated on write.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- valid  in  1  bus request, held high until ready
- ready  out  1  one-cycle transaction acknowledge
- wstrb  in  4  byte write strobes; 0 means read
- addr  in  32  byte address; only addr[7:2] decoded
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready=1
- cnt  out  NCH*WIDTH  live counter values, channel i at [i*WIDTH +: WIDTH]
- of  out  NCH  per-channel one-cycle overflow pulse
- irq  out  1  OR over channels of (STAT.OF & CTRL.IE)

Behaviour:
- Reset: every register, prescaler counter and counter is 0; ready=0, rdata=0, of=0, irq=0. A reset asserted mid-transaction drops ready and aborts the transaction.
- Address map:
  - channel = addr[7:4]; register = addr[3:2].
  - 0 CTRL: [0] EN, [1] ONESHOT, [2] IE, [31:16] PSC.
  - 1 MAX.
  - 2 CNT: read returns the live value; a write loads the counter.
  - 3 STAT: [0] OF sticky, write-1-to-clear.
  - channel >= NCH: reads return 0, writes are ignored, ready is still returned.
- Handshake:
  - Accept when valid=1 and ready=0.
  - ready=1 on the following cycle for exactly one cycle, then 0.
  - Latency is 1 cycle.
  - The write is applied in the accept cycle. rdata is registered in the accept cycle and reflects pre-write state.
  - Byte lanes are honoured per wstrb bit for every register. STAT W1C applies only to lanes that are strobed.
- Prescaler: while EN=1, psc_cnt increments every clk. When psc_cnt == PSC, a tick is generated and psc_cnt returns to 0. PSC=0 gives a tick every clk. While EN=0, psc_cnt is held at 0.
- Count on tick:
  - If cnt >= MAX: cnt <= 0, of[i] pulses high for exactly one clk on the next edge, STAT.OF <= 1. If ONESHOT=1, EN <= 0.
  - Otherwise cnt <= cnt+1.
- Compare uses >=, so writing MAX below the current cnt forces a wrap at the next tick. MAX=0 gives an overflow on every tick.
- Simultaneous events:
  - A CNT bus write and a tick in the same cycle: the bus write wins and the tick is dropped.
  - A STAT W1C and a hardware OF set in the same cycle: the set wins, so OF stays 1.
  - A CTRL write setting EN=0 in the same cycle as a one-shot overflow: the counter stops and of still pulses.
  - A CTRL write setting EN=1 while the one-shot hardware clears EN: the bus write wins.
- EN=0 freezes cnt. The value is retained and the counter resumes from it when re-enabled.
- irq is registered and combinational of flops only. It updates one cycle after the change in STAT or IE.

Decomposition:
- Package timer_array_pkg holds:
  - register offset constants REG_CTRL=0, REG_MAX=1, REG_CNT=2, REG_STAT=3;
  - CTRL bit positions CTRL_EN=0, CTRL_ONESHOT=1, CTRL_IE=2, CTRL_PSC_LSB=16;
  - a ctrl_t packed struct.
- Sub-module timer_channel (WIDTH parameter) holds one channel's registers, prescaler, compare and flags, with a per-channel write/byte-enable interface.
- The top level does bus decode, the ready/rdata registers, the generate loop over NCH, and the irq OR.

Test Plan:
- Reset, then read ch0 CTRL/MAX/CNT/STAT -> all 0. Each ready pulse is exactly 1 cycle, 1 cycle after valid.
- ch1: MAX=3, PSC=0, EN=1 periodic -> cnt sequence 0,1,2,3,0,1 on consecutive clks. of[1] pulses every 4 clks. STAT.OF reads 1 and clears after writing 1 to STAT.
- ch2: MAX=2, PSC=4, ONESHOT=1, IE=1 -> cnt increments every 5 clks. After 15 clks of[2] pulses once, EN reads 0, cnt holds 0, irq=1 until STAT is written with 1.
- ch0 running with MAX=100 and cnt=50: write MAX=10 -> wrap on the next tick with an of pulse, then period 11.
- Same-cycle collisions: CNT write of 0x55 coinciding with a tick -> cnt reads 0x55. W1C coinciding with an overflow -> OF stays 1.
- Byte-strobe write wstrb=4'b0010, wdata=0x0000AB00 to MAX (was 0x11223344) -> MAX reads 0x1122AB44. Access to channel 7 with NCH=4 -> rdata 0, ready returned, no channel state changed.

Source files
------------

// File: rtl/timer_array_pkg.sv
// -----------------------------------------------------------------------------
// timer_array_pkg
// Shared definitions for the timer array: register offsets within a channel,
// CTRL field positions, the CTRL register layout and a byte-lane merge helper.
// -----------------------------------------------------------------------------
package timer_array_pkg;

  // Register offsets inside one channel's 16-byte window (addr[3:2]).
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_MAX  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PSC_LSB = 16;

  // CTRL register image; the field order matches the bit positions above.
  typedef struct packed {
    logic [15:0] psc;
    logic [12:0] rsvd;
    logic        ie;
    logic        oneshot;
    logic        en;
  } ctrl_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_array_if.sv
// -----------------------------------------------------------------------------
// timer_array_if
// CPU native bus: valid/ready handshake with byte strobes (wstrb==0 is a read).
//   valid  master->slave  request, held until ready
//   ready  slave->master  one-cycle acknowledge
//   wstrb  master->slave  byte write strobes
//   addr   master->slave  byte address
//   wdata  master->slave  write data
//   rdata  slave->master  read data, valid while ready=1
// -----------------------------------------------------------------------------
interface timer_array_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One timer channel: CTRL/MAX/CNT/STAT registers, prescaler, compare and flags.
//   clk, resetn   clock, synchronous active-low reset
//   wr_i          write to this channel accepted this cycle
//   reg_sel_i     register offset (addr[3:2]), also selects the read mux
//   wstrb_i       byte strobes of the write
//   wdata_i       write data
//   rdata_o       selected register, pre-write state, zero-extended
//   cnt_o         live counter value
//   of_o          one-cycle overflow pulse
//   irq_o         STAT.OF & CTRL.IE (top registers the OR over channels)
// -----------------------------------------------------------------------------
module timer_channel
  import timer_array_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_i,
  input  logic [1:0]       reg_sel_i,
  input  logic [3:0]       wstrb_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             of_o,
  output logic             irq_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ctrl_t            ctrl_q, ctrl_d;
  logic [15:0]      psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             of_flag_q, of_flag_d;
  logic             of_pulse_q;

  logic ctrl_wr, max_wr, cnt_wr, stat_wr;
  logic psc_hit, tick, wrap;

  assign ctrl_wr = wr_i && (reg_sel_i == REG_CTRL);
  assign max_wr  = wr_i && (reg_sel_i == REG_MAX);
  assign cnt_wr  = wr_i && (reg_sel_i == REG_CNT);
  assign stat_wr = wr_i && (reg_sel_i == REG_STAT);

  assign psc_hit = ctrl_q.en && (psc_cnt_q == ctrl_q.psc);
  // A bus load of CNT takes precedence: the coinciding tick is dropped entirely.
  assign tick    = psc_hit && !cnt_wr;
  assign wrap    = tick && (cnt_q >= max_q);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    ctrl_d    = ctrl_q;
    psc_cnt_d = psc_cnt_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    of_flag_d = of_flag_q;

    // One-shot stop first, so a CTRL write in the same cycle overrides it.
    if (wrap && ctrl_q.oneshot) ctrl_d.en = 1'b0;
    if (ctrl_wr) begin
      ctrl_d      = ctrl_t'(merge_bytes(ctrl_q, wdata_i, wstrb_i));
      ctrl_d.rsvd = '0;
    end

    if (!ctrl_q.en)   psc_cnt_d = '0;
    else if (psc_hit) psc_cnt_d = '0;
    else              psc_cnt_d = psc_cnt_q + 16'd1;

    if (max_wr) max_d = WIDTH'(merge_bytes(32'(max_q), wdata_i, wstrb_i));

    if (cnt_wr)    cnt_d = WIDTH'(merge_bytes(32'(cnt_q), wdata_i, wstrb_i));
    else if (wrap) cnt_d = '0;
    else if (tick) cnt_d = cnt_q + ONE;

    // Clear before set: a hardware overflow in the same cycle keeps OF at 1.
    if (stat_wr && wstrb_i[0] && wdata_i[0]) of_flag_d = 1'b0;
    if (wrap)                                of_flag_d = 1'b1;
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is synchronous and active-low, matching the surrounding codebase.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q     <= '0;
      psc_cnt_q  <= '0;
      cnt_q      <= '0;
      max_q      <= '0;
      of_flag_q  <= 1'b0;
      of_pulse_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      psc_cnt_q  <= psc_cnt_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      of_flag_q  <= of_flag_d;
      of_pulse_q <= wrap;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_sel_i)
      REG_CTRL: rdata_o = ctrl_q;
      REG_MAX:  rdata_o = 32'(max_q);
      REG_CNT:  rdata_o = 32'(cnt_q);
      REG_STAT: rdata_o = {31'd0, of_flag_q};
      default:  rdata_o = '0;
    endcase
  end

  assign cnt_o = cnt_q;
  assign of_o  = of_pulse_q;
  assign irq_o = of_flag_q & ctrl_q.ie;

endmodule

// File: rtl/timer_array.sv
// -----------------------------------------------------------------------------
// timer_array
// Memory-mapped array of NCH prescaled up-counters on the CPU native bus.
//   clk, resetn  clock, synchronous active-low reset
//   bus          native bus slave (channel = addr[7:4], register = addr[3:2])
//   cnt          live counters, channel i at [i*WIDTH +: WIDTH]
//   of           per-channel one-cycle overflow pulses
//   irq          registered OR of (STAT.OF & CTRL.IE) over all channels
// -----------------------------------------------------------------------------
module timer_array
  import timer_array_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  timer_array_if.slave         bus,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       of,
  output logic                 irq
);

  logic        ready_q;
  logic [31:0] rdata_q, rd_mux;
  logic        irq_q;
  logic        accept, is_write;
  logic [3:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [31:0] ch_rdata [NCH];
  logic [NCH-1:0] ch_irq;
  logic        unused_addr;

  // A new request is taken only while no acknowledge is outstanding.
  assign accept   = bus.valid && !ready_q;
  assign is_write = |bus.wstrb;
  assign ch_sel   = bus.addr[7:4];
  assign reg_sel  = bus.addr[3:2];
  assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .wr_i      (accept && is_write && (ch_sel == 4'(gi))),
      .reg_sel_i (reg_sel),
      .wstrb_i   (bus.wstrb),
      .wdata_i   (bus.wdata),
      .rdata_o   (ch_rdata[gi]),
      .cnt_o     (cnt[gi*WIDTH +: WIDTH]),
      .of_o      (of[gi]),
      .irq_o     (ch_irq[gi])
    );
  end

  // Unpopulated channel numbers fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == 4'(i)) rd_mux = ch_rdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ready_q <= accept;
      rdata_q <= accept ? rd_mux : 32'd0;
      irq_q   <= |ch_irq;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_timer_array.sv
// -----------------------------------------------------------------------------
// tb_timer_array
// Directed bench for timer_array: a vector table for register access, byte
// strobes and out-of-range channels, plus cycle-exact sequences for periodic,
// one-shot, MAX-shrink and same-cycle collision behaviour.
// -----------------------------------------------------------------------------
module tb_timer_array;
  import timer_array_pkg::*;

  localparam int NCH   = 4;
  localparam int WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NCH*WIDTH-1:0] cnt;
  logic [NCH-1:0]       of;
  logic                 irq;

  timer_array_if bus();

  timer_array #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .cnt    (cnt),
    .of     (of),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int vec_cnt     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ch_cnt(input int ch);
    return cnt[ch*WIDTH +: WIDTH];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1ns after an edge with ready low. Accept happens on the next edge,
  // ready must be high right after it and low one cycle later.
  task automatic bus_op(input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd);
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wstrb = s;
    bus.wdata = d;
    step();
    rd = bus.rdata;
    check("ready_after_1", 32'(bus.ready), 32'd1);
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    step();
    check("ready_1_cycle", 32'(bus.ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    resetn    = 1'b0;
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_of",    32'(of), 32'd0);
    check("rst_irq",   32'(irq), 32'd0);
    check("rst_cnt",   32'(|cnt), 32'd0);

    // ---------------- register access table ----------------
    vecs[0]  = '{32'h00, 4'h0, 32'h0,        32'h0};         // ch0 CTRL
    vecs[1]  = '{32'h04, 4'h0, 32'h0,        32'h0};         // ch0 MAX
    vecs[2]  = '{32'h08, 4'h0, 32'h0,        32'h0};         // ch0 CNT
    vecs[3]  = '{32'h0C, 4'h0, 32'h0,        32'h0};         // ch0 STAT
    vecs[4]  = '{32'h34, 4'hF, 32'h11223344, 32'h0};         // ch3 MAX full write
    vecs[5]  = '{32'h34, 4'h2, 32'h0000AB00, 32'h11223344};  // lane 1 only, pre-write read
    vecs[6]  = '{32'h34, 4'h0, 32'h0,        32'h1122AB44};
    vecs[7]  = '{32'h74, 4'hF, 32'hDEADBEEF, 32'h0};         // ch7 MAX ignored
    vecs[8]  = '{32'h74, 4'h0, 32'h0,        32'h0};
    vecs[9]  = '{32'h34, 4'h0, 32'h0,        32'h1122AB44};  // no aliasing onto ch3
    vecs[10] = '{32'h70, 4'hF, 32'h00000007, 32'h0};         // ch7 CTRL ignored
    vecs[11] = '{32'h30, 4'h0, 32'h0,        32'h0};         // ch3 CTRL untouched

    for (int v = 0; v < 12; v++) begin
      bus_op(vecs[v].addr, vecs[v].wstrb, vecs[v].wdata, rd);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
    end

    // ---------------- ch1 periodic, MAX=3, PSC=0 ----------------
    bus_op(32'h14, 4'hF, 32'd3, rd);
    check("ch1_cnt_idle", ch_cnt(1), 32'd0);
    bus_op(32'h10, 4'hF, 32'h1, rd);
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("ch1_cnt_n%0d", n), ch_cnt(1), 32'(n % 4));
      check($sformatf("ch1_of_n%0d", n), 32'(of[1]), 32'(n % 4 == 0));
      if (n < 8) step();
    end
    bus_op(32'h1C, 4'h0, 32'h0, rd);
    check("ch1_stat_set", rd, 32'd1);
    bus_op(32'h10, 4'hF, 32'h0, rd);
    bus_op(32'h1C, 4'hE, 32'hFFFFFFFF, rd);       // lane 0 not strobed
    bus_op(32'h1C, 4'h0, 32'h0, rd);
    check("ch1_stat_unstrobed", rd, 32'd1);
    bus_op(32'h1C, 4'hF, 32'h1, rd);
    bus_op(32'h1C, 4'h0, 32'h0, rd);
    check("ch1_stat_cleared", rd, 32'd0);

    // ---------------- ch2 one-shot, MAX=2, PSC=4, IE ----------------
    bus_op(32'h24, 4'hF, 32'd2, rd);
    bus_op(32'h20, 4'hF, 32'h00040007, rd);
    for (int n = 1; n <= 25; n++) begin
      check($sformatf("ch2_cnt_n%0d", n), ch_cnt(2),
            (n < 5) ? 32'd0 : (n < 10) ? 32'd1 : (n < 15) ? 32'd2 : 32'd0);
      check($sformatf("ch2_of_n%0d", n), 32'(of[2]), 32'(n == 15));
      check($sformatf("ch2_irq_n%0d", n), 32'(irq), 32'(n >= 16));
      if (n < 25) step();
    end
    bus_op(32'h20, 4'h0, 32'h0, rd);
    check("ch2_ctrl_en_off", rd, 32'h00040006);
    bus_op(32'h28, 4'h0, 32'h0, rd);
    check("ch2_cnt_held", rd, 32'd0);
    check("ch2_irq_held", 32'(irq), 32'd1);
    bus_op(32'h2C, 4'hF, 32'h1, rd);
    check("ch2_irq_cleared", 32'(irq), 32'd0);

    // ---------------- ch0: shrink MAX below running count ----------------
    bus_op(32'h04, 4'hF, 32'd100, rd);
    bus_op(32'h08, 4'hF, 32'd50, rd);
    bus_op(32'h00, 4'hF, 32'h1, rd);
    check("ch0_cnt_run", ch_cnt(0), 32'd51);
    bus_op(32'h04, 4'hF, 32'd10, rd);
    for (int k = 0; k <= 22; k++) begin
      check($sformatf("ch0_cnt_k%0d", k), ch_cnt(0), 32'(k % 11));
      check($sformatf("ch0_of_k%0d", k), 32'(of[0]), 32'(k % 11 == 0));
      if (k < 22) step();
    end
    // W1C away from any wrap, then W1C landing exactly on the k=33 wrap.
    bus_op(32'h0C, 4'hF, 32'h1, rd);
    bus_op(32'h0C, 4'h0, 32'h0, rd);
    check("ch0_stat_clear", rd, 32'd0);
    repeat (6) step();
    bus_op(32'h0C, 4'hF, 32'h1, rd);
    bus_op(32'h0C, 4'h0, 32'h0, rd);
    check("ch0_w1c_vs_set", rd, 32'd1);

    // ---------------- ch1: CNT write colliding with a tick ----------------
    bus_op(32'h14, 4'hF, 32'h1000, rd);
    bus_op(32'h18, 4'hF, 32'h0, rd);
    bus_op(32'h10, 4'hF, 32'h1, rd);
    check("ch1_run_start", ch_cnt(1), 32'd1);
    bus_op(32'h18, 4'hF, 32'h55, rd);
    check("ch1_cnt_load_wins", ch_cnt(1), 32'h56);
    bus_op(32'h10, 4'hF, 32'h0, rd);
    bus_op(32'h18, 4'h0, 32'h0, rd);
    check("ch1_cnt_stopped", rd, 32'h57);
    repeat (5) step();
    check("ch1_cnt_frozen", ch_cnt(1), 32'h57);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
